// File: rtl/rysy_lsu.sv
// Load/store unit: aligns sub-word accesses onto a single-beat XLEN-wide bus,
// rejects misaligned or unsupported sizes, and aborts bus waits after TIMEOUT cycles.
module rysy_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we_in,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [XLEN-1:0]   wdata_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [XLEN-1:0]   rdata_out,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [XLEN/8-1:0] bus_be,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic [XLEN-1:0]   bus_rdata,
    input  logic              bus_ack
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_r;
    logic              we_r;
    logic              uns_r;
    logic [1:0]        size_r;
    logic [OFF_W-1:0]  off_r;
    logic [CNT_W-1:0]  wait_cnt_r;

    logic [OFF_W-1:0]  off_s;
    logic              illegal_s;
    logic [BE_W-1:0]   be_mask_s;
    logic [XLEN-1:0]   load_s;

    // Low-order bit mask covering the 2^sz bytes of an access.
    function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sz);
        logic [XLEN-1:0] m;
        m = '0;
        case (sz)
            2'd0:    m = XLEN'(64'h0000_0000_0000_00FF);
            2'd1:    m = XLEN'(64'h0000_0000_0000_FFFF);
            2'd2:    m = XLEN'(64'h0000_0000_FFFF_FFFF);
            2'd3:    m = '1;
            default: m = '1;
        endcase
        return m;
    endfunction

    // Truncate to the access size, then sign- or zero-fill the upper bits.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                               input logic [1:0]      sz,
                                               input logic            zx);
        logic [XLEN-1:0] m;
        logic            sb;
        m  = size_mask(sz);
        sb = 1'b0;
        case (sz)
            2'd0:    sb = raw[7];
            2'd1:    sb = raw[15];
            2'd2:    sb = raw[31];
            2'd3:    sb = raw[XLEN-1];
            default: sb = raw[XLEN-1];
        endcase
        return (raw & m) | ((!zx && sb) ? ~m : '0);
    endfunction

    // Decode the incoming request: lane offset, legality and unshifted byte-enable mask.
    always_comb begin
        off_s     = addr_in[OFF_W-1:0];
        illegal_s = 1'b0;
        be_mask_s = '0;
        case (size)
            2'd0: begin
                illegal_s = 1'b0;
                be_mask_s = BE_W'(8'h01);
            end
            2'd1: begin
                illegal_s = addr_in[0];
                be_mask_s = BE_W'(8'h03);
            end
            2'd2: begin
                illegal_s = |addr_in[1:0];
                be_mask_s = BE_W'(8'h0F);
            end
            2'd3: begin
                illegal_s = (XLEN == 32) || (|addr_in[2:0]);
                be_mask_s = BE_W'(8'hFF);
            end
            default: begin
                illegal_s = 1'b1;
                be_mask_s = '0;
            end
        endcase
    end

    // Right-align the returned lane and extend it per the latched size/sign mode.
    always_comb begin
        load_s = extend(bus_rdata >> {off_r, 3'b000}, size_r, uns_r);
    end

    // Access sequencer; every output is registered and cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= '0;
            we_r       <= 1'b0;
            uns_r      <= 1'b0;
            size_r     <= 2'd0;
            off_r      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata_out  <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req) begin
                        we_r   <= we_in;
                        uns_r  <= uns;
                        size_r <= size;
                        off_r  <= off_s;
                        busy   <= 1'b1;
                        if (illegal_s) begin
                            state_r <= RESP;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            state_r    <= ACCESS;
                            wait_cnt_r <= '0;
                            err        <= 1'b0;
                            bus_req    <= 1'b1;
                            bus_we     <= we_in;
                            bus_addr   <= {addr_in[ADDR_W-1:OFF_W], OFF_W'(0)};
                            bus_be     <= be_mask_s << off_s;
                            bus_wdata  <= (wdata_in & size_mask(size)) << {off_s, 3'b000};
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ACCESS: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (bus_ack) begin
                        state_r <= RESP;
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b0;
                        if (!we_r) begin
                            rdata_out <= load_s;
                        end else begin
                            rdata_out <= rdata_out;
                        end
                    end else if ((TIMEOUT != 0) && (wait_cnt_r == CNT_W'(TIMEOUT - 1))) begin
                        state_r <= RESP;
                        bus_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    err     <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    err     <= 1'b0;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rysy_lsu.sv
// Directed bench for rysy_lsu: a 32-bit instance with TIMEOUT=4 and a 64-bit instance
// with default timeout, each driven by hand-computed vectors.
module tb_rysy_lsu;

    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_fail   = 0;

    // 32-bit instance
    logic        req, we_in, uns, bus_ack;
    logic [1:0]  size;
    logic [31:0] addr_in, wdata_in, bus_rdata;
    logic        busy, done, err, bus_req, bus_we;
    logic [31:0] rdata_out, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    // 64-bit instance
    logic        req64, we64, uns64, ack64;
    logic [1:0]  size64;
    logic [31:0] addr64;
    logic [63:0] wdata64, rdata64;
    logic        busy64, done64, err64, bus_req64, bus_we64;
    logic [63:0] rdata_out64, bus_wdata64;
    logic [31:0] bus_addr64;
    logic [7:0]  bus_be64;

    rysy_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req(req), .we_in(we_in), .size(size), .uns(uns),
        .addr_in(addr_in), .wdata_in(wdata_in), .busy(busy), .done(done), .err(err),
        .rdata_out(rdata_out), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    rysy_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst), .req(req64), .we_in(we64), .size(size64), .uns(uns64),
        .addr_in(addr64), .wdata_in(wdata64), .busy(busy64), .done(done64), .err(err64),
        .rdata_out(rdata_out64), .bus_req(bus_req64), .bus_we(bus_we64), .bus_addr(bus_addr64),
        .bus_be(bus_be64), .bus_wdata(bus_wdata64), .bus_rdata(rdata64), .bus_ack(ack64)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we_in = w; size = sz; uns = u; addr_in = a; wdata_in = d;
        step();
        req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we_in = 1'b0; uns = 1'b0; bus_ack = 1'b0; size = 2'd0;
        addr_in = 32'h0; wdata_in = 32'h0; bus_rdata = 32'h0;
        req64 = 1'b0; we64 = 1'b0; uns64 = 1'b0; ack64 = 1'b0; size64 = 2'd0;
        addr64 = 32'h0; wdata64 = 64'h0; rdata64 = 64'h0;
        step(); step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_bus_req", 64'(bus_req), 64'd0);
        check("rst_bus_we", 64'(bus_we), 64'd0);
        check("rst_bus_addr", 64'(bus_addr), 64'd0);
        check("rst_bus_be", 64'(bus_be), 64'd0);
        check("rst_bus_wdata", 64'(bus_wdata), 64'd0);
        check("rst_rdata", 64'(rdata_out), 64'd0);
        check("rst_rdata64", rdata_out64, 64'd0);
        rst = 1'b0;
        step();

        // Signed byte load at 0x1003, ack two cycles after bus_req rises
        issue(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0);
        check("lb_bus_req", 64'(bus_req), 64'd1);
        check("lb_busy", 64'(busy), 64'd1);
        check("lb_bus_addr", 64'(bus_addr), 64'h1000);
        check("lb_bus_be", 64'(bus_be), 64'b1000);
        check("lb_bus_we", 64'(bus_we), 64'd0);
        step();
        check("lb_hold_req", 64'(bus_req), 64'd1);
        check("lb_no_done", 64'(done), 64'd0);
        step();
        bus_ack = 1'b1; bus_rdata = 32'h8011_2233;
        check("lb_hold_addr", 64'(bus_addr), 64'h1000);
        step();
        bus_ack = 1'b0;
        check("lb_done", 64'(done), 64'd1);
        check("lb_err", 64'(err), 64'd0);
        check("lb_rdata", 64'(rdata_out), 64'hFFFF_FF80);
        check("lb_req_drop", 64'(bus_req), 64'd0);
        step();
        check("lb_done_pulse", 64'(done), 64'd0);
        check("lb_idle", 64'(busy), 64'd0);

        // Half store at 0x1002 with immediate ack
        issue(1'b1, 2'd1, 1'b0, 32'h0000_1002, 32'h0000_ABCD);
        check("sh_bus_we", 64'(bus_we), 64'd1);
        check("sh_bus_be", 64'(bus_be), 64'b1100);
        check("sh_bus_wdata", 64'(bus_wdata), 64'hABCD_0000);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check("sh_done", 64'(done), 64'd1);
        check("sh_err", 64'(err), 64'd0);
        check("sh_rdata_hold", 64'(rdata_out), 64'hFFFF_FF80);
        step();

        // Byte store with junk in upper wdata bits: unused lanes must be zero
        issue(1'b1, 2'd0, 1'b0, 32'h0000_1001, 32'h1234_56EF);
        check("sb_bus_be", 64'(bus_be), 64'b0010);
        check("sb_bus_wdata", 64'(bus_wdata), 64'h0000_EF00);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        step();

        // Misaligned word load is rejected without touching the bus
        issue(1'b0, 2'd2, 1'b0, 32'h0000_1001, 32'h0);
        check("mis_bus_req", 64'(bus_req), 64'd0);
        check("mis_done", 64'(done), 64'd1);
        check("mis_err", 64'(err), 64'd1);
        step();
        check("mis_done_pulse", 64'(done), 64'd0);
        check("mis_bus_req2", 64'(bus_req), 64'd0);
        check("mis_idle", 64'(busy), 64'd0);

        // Dword is unsupported on a 32-bit bus even when aligned
        issue(1'b0, 2'd3, 1'b0, 32'h0000_2000, 32'h0);
        check("dw32_err", 64'(err), 64'd1);
        check("dw32_bus_req", 64'(bus_req), 64'd0);
        step();

        // No ack: timeout after four bus_req cycles, rdata_out untouched
        issue(1'b0, 2'd2, 1'b0, 32'h0000_2000, 32'h0);
        check("to_req_c1", 64'(bus_req), 64'd1);
        for (int i = 2; i <= 4; i++) begin
            step();
            check("to_req_held", 64'(bus_req), 64'd1);
            check("to_no_done", 64'(done), 64'd0);
        end
        step();
        check("to_done", 64'(done), 64'd1);
        check("to_err", 64'(err), 64'd1);
        check("to_req_drop", 64'(bus_req), 64'd0);
        check("to_rdata_hold", 64'(rdata_out), 64'hFFFF_FF80);
        step();
        check("to_idle", 64'(busy), 64'd0);

        // Ack arriving on the timeout cycle wins
        issue(1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0);
        step(); step(); step();
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        step();
        bus_ack = 1'b0;
        check("race_done", 64'(done), 64'd1);
        check("race_err", 64'(err), 64'd0);
        check("race_rdata", 64'(rdata_out), 64'h1234_5678);
        step();

        // Reset on the second ACCESS cycle aborts the access
        issue(1'b0, 2'd0, 1'b1, 32'h0000_1001, 32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_bus_req", 64'(bus_req), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        step();
        check("abort_no_done", 64'(done), 64'd0);
        issue(1'b0, 2'd1, 1'b1, 32'h0000_1002, 32'h0);
        check("post_bus_req", 64'(bus_req), 64'd1);
        check("post_bus_be", 64'(bus_be), 64'b1100);
        bus_ack = 1'b1; bus_rdata = 32'hF00D_1234;
        step();
        bus_ack = 1'b0;
        check("post_done", 64'(done), 64'd1);
        check("post_rdata", 64'(rdata_out), 64'h0000_F00D);
        step();

        // 64-bit: zero-extending word load at 0x4
        req64 = 1'b1; we64 = 1'b0; size64 = 2'd2; uns64 = 1'b1; addr64 = 32'h4;
        step();
        req64 = 1'b0;
        check("w64_bus_be", 64'(bus_be64), 64'hF0);
        check("w64_bus_addr", 64'(bus_addr64), 64'h0);
        check("w64_bus_req", 64'(bus_req64), 64'd1);
        ack64 = 1'b1; rdata64 = 64'h8000_0000_0000_0000;
        step();
        ack64 = 1'b0;
        check("w64_done", 64'(done64), 64'd1);
        check("w64_err", 64'(err64), 64'd0);
        check("w64_rdata", rdata_out64, 64'h0000_0000_8000_0000);
        step();
        check("w64_idle", 64'(busy64), 64'd0);

        // 64-bit: byte store into the top lane
        req64 = 1'b1; we64 = 1'b1; size64 = 2'd0; uns64 = 1'b0; addr64 = 32'h17; wdata64 = 64'h0000_0000_0000_00AB;
        step();
        req64 = 1'b0;
        check("b64_bus_we", 64'(bus_we64), 64'd1);
        check("b64_bus_be", 64'(bus_be64), 64'h80);
        check("b64_bus_addr", 64'(bus_addr64), 64'h10);
        check("b64_bus_wdata", bus_wdata64, 64'hAB00_0000_0000_0000);
        ack64 = 1'b1;
        step();
        ack64 = 1'b0;
        check("b64_done", 64'(done64), 64'd1);
        check("b64_rdata_hold", rdata_out64, 64'h0000_0000_8000_0000);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
